// File: rtl/ddram_bram_slave.sv
// ddram_bram_slave: on-chip BRAM answering the ddram Avalon-MM burst master with 64-bit byte-enabled words
module ddram_bram_slave #(
  parameter int DEPTH_LOG2 = 14
) (
  input  logic        DDRAM_CLK,
  input  logic        DDRAM_RST_N,
  output logic        DDRAM_BUSY,
  input  logic [7:0]  DDRAM_BURSTCNT,
  input  logic [28:0] DDRAM_ADDR,
  output logic [63:0] DDRAM_DOUT,
  output logic        DDRAM_DOUT_READY,
  input  logic        DDRAM_RD,
  input  logic [63:0] DDRAM_DIN,
  input  logic [7:0]  DDRAM_BE,
  input  logic        DDRAM_WE
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WR   = 2'd1;
  localparam logic [1:0] S_RD   = 2'd2;
  localparam logic [DEPTH_LOG2-1:0] ADDR_ONE = 1;

  logic [63:0] mem [2**DEPTH_LOG2];
  logic [1:0] state_q, state_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d, wr_addr;
  logic [7:0] cnt_q, cnt_d, n;
  logic [63:0] dout_q, dout_d;
  logic rvalid_q, rvalid_d;
  logic accept_wr, accept_rd, wr_en, rd_en;
  logic addr_unused;

  // Upper address bits alias onto the BRAM and are deliberately ignored
  assign addr_unused      = ^DDRAM_ADDR[28:DEPTH_LOG2];
  assign DDRAM_BUSY       = (state_q == S_RD) | rvalid_q;
  assign DDRAM_DOUT       = dout_q;
  assign DDRAM_DOUT_READY = rvalid_q;

  // Command decode, burst address/beat bookkeeping and read-port control
  always_comb begin
    n         = (DDRAM_BURSTCNT == 8'd0) ? 8'd1 : DDRAM_BURSTCNT;
    accept_wr = (state_q == S_IDLE) & DDRAM_WE & ~DDRAM_BUSY;
    accept_rd = (state_q == S_IDLE) & DDRAM_RD & ~DDRAM_WE & ~DDRAM_BUSY;
    wr_en     = DDRAM_RST_N & (accept_wr | ((state_q == S_WR) & DDRAM_WE));
    wr_addr   = (state_q == S_IDLE) ? DDRAM_ADDR[DEPTH_LOG2-1:0] : addr_q;
    rd_en     = (state_q == S_RD);
    state_d   = state_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    if (accept_wr) begin
      addr_d  = wr_addr + ADDR_ONE;
      cnt_d   = n - 8'd1;
      state_d = (n == 8'd1) ? S_IDLE : S_WR;
    end else if (accept_rd) begin
      addr_d  = DDRAM_ADDR[DEPTH_LOG2-1:0];
      cnt_d   = n;
      state_d = S_RD;
    end else if (((state_q == S_WR) & DDRAM_WE) | rd_en) begin
      addr_d  = addr_q + ADDR_ONE;
      cnt_d   = cnt_q - 8'd1;
      state_d = (cnt_q == 8'd1) ? S_IDLE : state_q;
    end
    rvalid_d = rd_en;
    dout_d   = rd_en ? mem[addr_q] : dout_q;
  end

  // Control and registered read output; reset aborts any burst at once
  always_ff @(posedge DDRAM_CLK or negedge DDRAM_RST_N) begin
    if (!DDRAM_RST_N) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      cnt_q    <= '0;
      dout_q   <= '0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Byte-enabled BRAM write port; contents are never reset
  always_ff @(posedge DDRAM_CLK) begin
    for (int i = 0; i < 8; i++)
      if (wr_en && DDRAM_BE[i]) mem[wr_addr][8*i +: 8] <= DDRAM_DIN[8*i +: 8];
  end
endmodule

// File: tb/tb_ddram_bram_slave.sv
// tb_ddram_bram_slave: directed checks of the BRAM burst slave with a 16-word BRAM
module tb_ddram_bram_slave;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        busy;
  logic [7:0]  burstcnt = '0;
  logic [28:0] addr = '0;
  logic [63:0] dout;
  logic        dout_ready;
  logic        rd = 1'b0;
  logic [63:0] din = '0;
  logic [7:0]  be = '0;
  logic        we = 1'b0;
  int n_cmp = 0;
  int n_err = 0;

  ddram_bram_slave #(.DEPTH_LOG2(4)) dut (
    .DDRAM_CLK(clk), .DDRAM_RST_N(rst_n), .DDRAM_BUSY(busy),
    .DDRAM_BURSTCNT(burstcnt), .DDRAM_ADDR(addr), .DDRAM_DOUT(dout),
    .DDRAM_DOUT_READY(dout_ready), .DDRAM_RD(rd), .DDRAM_DIN(din),
    .DDRAM_BE(be), .DDRAM_WE(we)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic wr_burst(input logic [28:0] a, input int n, input logic [63:0] base, input logic [7:0] b);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("wr_busy", {63'd0, busy}, 64'd0);
      we = 1'b1; addr = a; burstcnt = 8'(n); din = base + 64'(i); be = b;
    end
    @(negedge clk);
    we = 1'b0;
  endtask

  task automatic do_read(input logic [28:0] a, input logic [7:0] bc, input int nb,
                         input logic [63:0] base, input int period);
    @(negedge clk);
    chk("rd_idle_busy", {63'd0, busy}, 64'd0);
    rd = 1'b1; addr = a; burstcnt = bc;
    @(negedge clk);
    rd = 1'b0;
    chk("rd_t1_busy", {63'd0, busy}, 64'd1);
    chk("rd_t1_ready", {63'd0, dout_ready}, 64'd0);
    for (int k = 0; k < nb; k++) begin
      @(negedge clk);
      chk("rd_beat_ready", {63'd0, dout_ready}, 64'd1);
      chk("rd_beat_busy", {63'd0, busy}, 64'd1);
      chk("rd_beat_data", dout, base + 64'(k % period));
    end
    @(negedge clk);
    chk("rd_end_busy", {63'd0, busy}, 64'd0);
    chk("rd_end_ready", {63'd0, dout_ready}, 64'd0);
    chk("rd_end_hold", dout, base + 64'((nb - 1) % period));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_ready", {63'd0, dout_ready}, 64'd0);
    chk("rst_dout", dout, 64'd0);
    rst_n = 1'b1;

    wr_burst(29'h10, 1, 64'h1122334455667788, 8'hFF);
    do_read(29'h10, 8'd1, 1, 64'h1122334455667788, 256);

    wr_burst(29'h10, 1, 64'hAAAAAAAABBBBBBBB, 8'h0F);
    do_read(29'h10, 8'd1, 1, 64'h11223344BBBBBBBB, 256);

    @(negedge clk);
    we = 1'b1; addr = 29'h20; burstcnt = 8'd4; din = 64'd1; be = 8'hFF;
    @(negedge clk);
    chk("wrs_busy1", {63'd0, busy}, 64'd0);
    din = 64'd2; addr = 29'h7; burstcnt = 8'd1;
    @(negedge clk);
    we = 1'b0; din = 64'hDEAD;
    @(negedge clk);
    chk("wrs_stall_busy", {63'd0, busy}, 64'd0);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0; we = 1'b1; din = 64'd3;
    @(negedge clk);
    din = 64'd4;
    @(negedge clk);
    we = 1'b0;
    do_read(29'h20, 8'd4, 4, 64'd1, 256);

    wr_burst(29'hE, 3, 64'd7, 8'hFF);
    do_read(29'h1000E, 8'd3, 3, 64'd7, 256);
    do_read(29'h0, 8'd1, 1, 64'd9, 256);

    wr_burst(29'h0, 16, 64'h100, 8'hFF);
    do_read(29'h3, 8'd0, 1, 64'h103, 256);
    do_read(29'h0, 8'd255, 255, 64'h100, 16);

    @(negedge clk);
    rd = 1'b1; addr = 29'h0; burstcnt = 8'd8;
    @(negedge clk);
    rd = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_mid_ready_pre", {63'd0, dout_ready}, 64'd1);
    chk("rst_mid_data_pre", dout, 64'h103);
    #1 rst_n = 1'b0;
    we = 1'b1; addr = 29'h5; burstcnt = 8'd1; din = 64'hBAD; be = 8'hFF;
    #1;
    chk("rst_mid_ready", {63'd0, dout_ready}, 64'd0);
    chk("rst_mid_busy", {63'd0, busy}, 64'd0);
    chk("rst_mid_dout", dout, 64'd0);
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_ready", {63'd0, dout_ready}, 64'd0);
    end
    do_read(29'h5, 8'd1, 1, 64'h105, 256);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
